alu_sequencer: RTL

Initiator-side controller for the team's `alu` block: accepts ALU commands over a valid/ready interface and drives the ALU's enable, op_code, op0 and op1 inputs. It waits a parameterised latency, samples the ALU result, and returns it over a valid/ready response interface. It sits between the instruction/control path and `alu`, replacing ad-hoc direct driving of ALU ports.

---
 rtl/alu_pkg.sv | 10 +
 rtl/alu.sv | 20 ++
 rtl/alu_sequencer.sv | 85 ++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, sequencer state encoding and default widths shared with alu
package alu_pkg;
  localparam int DATA_W = 4;
  localparam int OPCODE_W = 2;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational add/sub/mul on enable, output 0 when idle or reserved opcode
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int OPCODE_WIDTH = OPCODE_W
) (
  input  logic                    enable,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic [DATA_WIDTH-1:0]   op0,
  input  logic [DATA_WIDTH-1:0]   op1,
  output logic [DATA_WIDTH-1:0]   out
);
  always_comb begin
    out = !enable ? '0 :
          op_code == OPCODE_WIDTH'(OP_ADD) ? op0 + op1 :
          op_code == OPCODE_WIDTH'(OP_SUB) ? op0 - op1 :
          op_code == OPCODE_WIDTH'(OP_MUL) ? op0 * op1 : '0;
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready command front-end that issues to alu, waits its latency and returns the result
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int ALU_LATENCY = 0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OPCODE_WIDTH-1:0] cmd_op,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  output logic                    alu_enable,
  output logic [OPCODE_WIDTH-1:0] alu_op_code,
  output logic [DATA_WIDTH-1:0]   alu_op0,
  output logic [DATA_WIDTH-1:0]   alu_op1,
  input  logic [DATA_WIDTH-1:0]   alu_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic [CNT_WIDTH-1:0]    ops_done,
  output logic                    busy
);
  localparam int LW = ALU_LATENCY > 1 ? $clog2(ALU_LATENCY) : 1;
  state_t state;
  logic [LW-1:0] lat_cnt;
  assign cmd_ready = state == IDLE && !reset;
  assign busy = state != IDLE;
  assign rsp_valid = state == RESP;
  assign alu_enable = state == ISSUE || state == WAIT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      lat_cnt <= '0;
      alu_op_code <= '0;
      alu_op0 <= '0;
      alu_op1 <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      ops_done <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          if (cmd_op == OPCODE_WIDTH'(OP_RSVD)) begin
            state <= RESP;
            rsp_data <= '0;
            rsp_err <= 1'b1;
          end else begin
            state <= ISSUE;
            alu_op_code <= cmd_op;
            alu_op0 <= cmd_a;
            alu_op1 <= cmd_b;
          end
        end
        ISSUE: if (ALU_LATENCY == 0) begin
          rsp_data <= alu_out;
          state <= RESP;
        end else begin
          lat_cnt <= LW'(ALU_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: if (lat_cnt == '0) begin
          rsp_data <= alu_out;
          state <= RESP;
        end else begin
          lat_cnt <= lat_cnt - 1'b1;
        end
        RESP: if (rsp_ready) begin
          ops_done <= ops_done + 1'b1;
          rsp_err <= 1'b0;
          alu_op_code <= '0;
          alu_op0 <= '0;
          alu_op1 <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
